dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 153 +++++++++++++++
 tb/tb_dmem_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, response LATENCY cycles after accept.
// Optional MISALIGN_TRAP_EN turns misaligned half/word accesses into errors instead of aligning them down.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [2:0]  lat_funct3;
    logic [AW+1:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] mem [DEPTH];

    logic          accept, enter_resp;
    logic          cur_we, cur_err;
    logic [2:0]    cur_funct3;
    logic [AW+1:0] cur_addr;
    logic [31:0]   cur_wdata;
    logic [AW-1:0] word_idx;
    logic [1:0]    off;
    logic [3:0]    be;
    logic [31:0]   wdata_lane, word_rd, byte_sh, half_sh, load_val;

    // Address bits above the memory size wrap around and are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:AW+2];

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = (LATENCY == 1) ? RESP : WAIT;
            end
            WAIT: if (cnt == 4'd1) state_next = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept     = (state == IDLE) && req_valid;
    assign enter_resp = (state != RESP) && (state_next == RESP);

    // With LATENCY = 1 the request is served on its accept edge, so use the live inputs in IDLE.
    assign cur_we     = (state == IDLE) ? req_we              : lat_we;
    assign cur_funct3 = (state == IDLE) ? req_funct3          : lat_funct3;
    assign cur_addr   = (state == IDLE) ? req_addr[AW+1:0]    : lat_addr;
    assign cur_wdata  = (state == IDLE) ? req_wdata           : lat_wdata;

    always_comb begin
        word_idx = cur_addr[AW+1:2];
        off      = cur_addr[1:0];
        cur_err  = 1'b0;
        case (cur_funct3)
            3'b011, 3'b110, 3'b111: cur_err = 1'b1;
            3'b100, 3'b101:         cur_err = cur_we;
            default:                cur_err = 1'b0;
        endcase
`ifdef MISALIGN_TRAP_EN
        if ((cur_funct3[1:0] == 2'b01) && off[0]) cur_err = 1'b1;
        if ((cur_funct3 == 3'b010) && (off != 2'b00)) cur_err = 1'b1;
`endif
        case (cur_funct3[1:0])
            2'b00: begin
                be         = 4'b0001 << off;
                wdata_lane = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be         = off[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{cur_wdata[15:0]}};
            end
            default: begin
                be         = 4'b1111;
                wdata_lane = cur_wdata;
            end
        endcase
        word_rd = mem[word_idx];
        byte_sh = word_rd >> {off, 3'b000};
        half_sh = word_rd >> {off[1], 4'b0000};
        case (cur_funct3)
            3'b000:  load_val = {{24{byte_sh[7]}}, byte_sh[7:0]};
            3'b001:  load_val = {{16{half_sh[15]}}, half_sh[15:0]};
            3'b100:  load_val = {24'd0, byte_sh[7:0]};
            3'b101:  load_val = {16'd0, half_sh[15:0]};
            default: load_val = word_rd;
        endcase
    end

    // Memory is never reset; a store only lands on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && !cur_err && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            lat_we     <= 1'b0;
            lat_funct3 <= 3'd0;
            lat_addr   <= '0;
            lat_wdata  <= 32'd0;
            rsp_rdata  <= 32'd0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                lat_we     <= req_we;
                lat_funct3 <= req_funct3;
                lat_addr   <= req_addr[AW+1:0];
                lat_wdata  <= req_wdata;
                cnt        <= 4'(LATENCY - 1);
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                rsp_err   <= cur_err;
                rsp_rdata <= (cur_we || cur_err) ? 32'd0 : load_val;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY = 2, DEPTH = 256); expectations are hand-computed.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    dmem_responder #(.DEPTH(256), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Drives one request, scrambles req_* after the accept edge, and waits (bounded) for rsp_valid.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat,
                         output logic [31:0] rdata, output logic err);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b010;
        req_addr = 32'h0000_0010; req_wdata = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0)
            $display("[TB] FAIL reset_outputs: got valid=%b rdata=%h err=%b want 0/00000000/0",
                     rsp_valid, rsp_rdata, rsp_err);
        else pass_cnt++;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
            $display("[TB] FAIL reset_release: got ready=%b valid=%b want 1/0", req_ready, rsp_valid);
        else pass_cnt++;
    endtask

    task automatic test_word();
        int lat; logic [31:0] rd; logic er;
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, er);
        total_cnt++;
        if (lat !== 2 || rd !== 32'd0 || er !== 1'b0)
            $display("[TB] FAIL sw_10: got lat=%0d rdata=%h err=%b want 2/00000000/0", lat, rd, er);
        else pass_cnt++;
        ack();
        issue(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er);
        total_cnt++;
        if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0)
            $display("[TB] FAIL lw_10: got lat=%0d rdata=%h err=%b want 2/deadbeef/0", lat, rd, er);
        else pass_cnt++;
        ack();
    endtask

    task automatic test_subword();
        int lat; logic [31:0] rd; logic er;
        logic [31:0] exp_tab [7];
        logic        we_tab  [7];
        logic [2:0]  f3_tab  [7];
        logic [31:0] a_tab   [7];
        logic [31:0] wd_tab  [7];
        we_tab = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        f3_tab = '{3'b010, 3'b000, 3'b000, 3'b100, 3'b010, 3'b010, 3'b001};
        a_tab  = '{32'h10, 32'h13, 32'h13, 32'h13, 32'h10, 32'h14, 32'h16};
        wd_tab = '{32'h0, 32'hABCDEF80, 32'h0, 32'h0, 32'h0, 32'h11223344, 32'hFFFF8001};
        exp_tab = '{32'h0, 32'h0, 32'hFFFFFF80, 32'h00000080, 32'h80000000, 32'h0, 32'h0};
        for (int i = 0; i < 7; i++) begin
            issue(we_tab[i], f3_tab[i], a_tab[i], wd_tab[i], lat, rd, er);
            total_cnt++;
            if (lat !== 2 || rd !== exp_tab[i] || er !== 1'b0)
                $display("[TB] FAIL subword_%0d: got lat=%0d rdata=%h err=%b want 2/%h/0",
                         i, lat, rd, er, exp_tab[i]);
            else pass_cnt++;
            ack();
        end
        f3_tab  = '{3'b001, 3'b101, 3'b010, 3'b001, 3'b101, 3'b000, 3'b100};
        a_tab   = '{32'h16, 32'h16, 32'h14, 32'h14, 32'h14, 32'h15, 32'h17};
        exp_tab = '{32'hFFFF8001, 32'h00008001, 32'h80013344, 32'h00003344,
                    32'h00003344, 32'h00000033, 32'h00000080};
        for (int i = 0; i < 7; i++) begin
            issue(1'b0, f3_tab[i], a_tab[i], 32'h0, lat, rd, er);
            total_cnt++;
            if (lat !== 2 || rd !== exp_tab[i] || er !== 1'b0)
                $display("[TB] FAIL subload_%0d: got lat=%0d rdata=%h err=%b want 2/%h/0",
                         i, lat, rd, er, exp_tab[i]);
            else pass_cnt++;
            ack();
        end
    endtask

    task automatic test_stall();
        int lat; logic [31:0] rd; logic er;
        issue(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er);
        total_cnt++;
        if (lat !== 2 || rd !== 32'h80000000 || er !== 1'b0)
            $display("[TB] FAIL stall_lw: got lat=%0d rdata=%h err=%b want 2/80000000/0", lat, rd, er);
        else pass_cnt++;
        // A competing store is presented during the stall; it must be ignored.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h80000000 || rsp_err !== 1'b0 || req_ready !== 1'b0)
                $display("[TB] FAIL stall_hold_%0d: got valid=%b rdata=%h err=%b ready=%b want 1/80000000/0/0",
                         c, rsp_valid, rsp_rdata, rsp_err, req_ready);
            else pass_cnt++;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; rsp_ready = 1'b0;
        total_cnt++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
            $display("[TB] FAIL stall_release: got ready=%b valid=%b want 1/0", req_ready, rsp_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] rd; logic er;
        issue(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, lat, rd, er);
        ack();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk) rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
                $display("[TB] FAIL abort_idle_%0d: got valid=%b ready=%b want 0/1", c, rsp_valid, req_ready);
            else pass_cnt++;
        end
        issue(1'b0, 3'b010, 32'h20, 32'h0, lat, rd, er);
        total_cnt++;
        if (lat !== 2 || rd !== 32'hCAFEF00D || er !== 1'b0)
            $display("[TB] FAIL abort_lw_20: got lat=%0d rdata=%h err=%b want 2/cafef00d/0", lat, rd, er);
        else pass_cnt++;
        ack();
        issue(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er);
        total_cnt++;
        if (lat !== 2 || rd !== 32'h80000000 || er !== 1'b0)
            $display("[TB] FAIL mem_survives_rst: got lat=%0d rdata=%h err=%b want 2/80000000/0", lat, rd, er);
        else pass_cnt++;
        ack();
    endtask

    task automatic test_misalign();
        int lat; logic [31:0] rd; logic er;
        logic [31:0] exp_rd, exp_w0;
        logic        exp_er;
`ifdef MISALIGN_TRAP_EN
        exp_rd = 32'h0; exp_er = 1'b1; exp_w0 = 32'h0BADC0DE;
`else
        exp_rd = 32'h0BADC0DE; exp_er = 1'b0; exp_w0 = 32'hFFFFFFFF;
`endif
        issue(1'b1, 3'b010, 32'h0, 32'h0BADC0DE, lat, rd, er);
        ack();
        issue(1'b0, 3'b010, 32'h402, 32'h0, lat, rd, er);
        total_cnt++;
        if (lat !== 2 || rd !== exp_rd || er !== exp_er)
            $display("[TB] FAIL lw_402: got lat=%0d rdata=%h err=%b want 2/%h/%b", lat, rd, er, exp_rd, exp_er);
        else pass_cnt++;
        ack();
        issue(1'b1, 3'b010, 32'h3, 32'hFFFFFFFF, lat, rd, er);
        total_cnt++;
        if (lat !== 2 || rd !== 32'h0 || er !== exp_er)
            $display("[TB] FAIL sw_3: got lat=%0d rdata=%h err=%b want 2/00000000/%b", lat, rd, er, exp_er);
        else pass_cnt++;
        ack();
        issue(1'b0, 3'b010, 32'h0, 32'h0, lat, rd, er);
        total_cnt++;
        if (lat !== 2 || rd !== exp_w0 || er !== 1'b0)
            $display("[TB] FAIL lw_0_after_sw_3: got lat=%0d rdata=%h err=%b want 2/%h/0", lat, rd, er, exp_w0);
        else pass_cnt++;
        ack();
    endtask

    task automatic test_illegal();
        int lat; logic [31:0] rd; logic er;
        logic        we_tab [4];
        logic [2:0]  f3_tab [4];
        we_tab = '{1'b0, 1'b0, 1'b1, 1'b1};
        f3_tab = '{3'b111, 3'b011, 3'b100, 3'b101};
        for (int i = 0; i < 4; i++) begin
            issue(we_tab[i], f3_tab[i], 32'h10, 32'h0, lat, rd, er);
            total_cnt++;
            if (lat !== 2 || rd !== 32'h0 || er !== 1'b1)
                $display("[TB] FAIL illegal_%0d: got lat=%0d rdata=%h err=%b want 2/00000000/1", i, lat, rd, er);
            else pass_cnt++;
            ack();
        end
        issue(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er);
        total_cnt++;
        if (lat !== 2 || rd !== 32'h80000000 || er !== 1'b0)
            $display("[TB] FAIL illegal_no_write: got lat=%0d rdata=%h err=%b want 2/80000000/0", lat, rd, er);
        else pass_cnt++;
        ack();
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_stall();
        test_reset_abort();
        test_misalign();
        test_illegal();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] simulation timed out");
    end

endmodule
